// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU constants for control bits, attributes and palette width
package ppu_pkg;

  localparam int CTRL2_SHOW_BG_LEFT  = 1;
  localparam int CTRL2_SHOW_SPR_LEFT = 2;
  localparam int CTRL2_BG_EN         = 3;
  localparam int CTRL2_SPR_EN        = 4;

  localparam int ATTR_BEHIND = 5;

  localparam int PAL_W = 8;

endpackage

// File: rtl/pixel_prio_resolve.sv
// rtl/pixel_prio_resolve.sv - per-pixel sprite/background priority and sprite-0 hit
module pixel_prio_resolve #(
  parameter int NUM_SPRITES = 8
) (
  input  logic [2*NUM_SPRITES-1:0] spr_val_i,
  input  logic [1:0]               bg_val_i,
  input  logic                     spr_vis_i,
  input  logic                     bg_vis_i,
  input  logic                     hit_ok_i,
  output logic [2:0]               win_idx_o,
  output logic [1:0]               win_val_o,
  output logic [1:0]               bg_val_o,
  output logic                     hit_o
);

  // Scan from the lowest priority up so the lowest opaque index is the last writer.
  always_comb begin
    win_idx_o = '0;
    win_val_o = '0;
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      if (spr_vis_i && spr_val_i[2*s +: 2] != 2'b00) begin
        win_idx_o = 3'(s);
        win_val_o = spr_val_i[2*s +: 2];
      end
    end
  end

  assign bg_val_o = bg_vis_i ? bg_val_i : 2'b00;
  assign hit_o    = spr_vis_i && (spr_val_i[1:0] != 2'b00) && (bg_val_o != 2'b00) && hit_ok_i;

endmodule

// File: rtl/pixel_compositor.sv
// rtl/pixel_compositor.sv - two-stage sprite/background compositor with sprite-0 hit
module pixel_compositor
  import ppu_pkg::*;
#(
  parameter int NUM_SPRITES  = 8,
  parameter int PIX_PER_WORD = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_SPRITES*PIX_PER_WORD-1:0] spr_pat_lo,
  input  logic [NUM_SPRITES*PIX_PER_WORD-1:0] spr_pat_hi,
  input  logic [NUM_SPRITES*8-1:0]          spr_attr,
  input  logic [NUM_SPRITES*32-1:0]         spr_colors,
  input  logic [PIX_PER_WORD-1:0]           bg_pat_lo,
  input  logic [PIX_PER_WORD-1:0]           bg_pat_hi,
  input  logic [31:0]                       bg_colors,
  input  logic [7:0]                        ppu_ctrl2,
  input  logic [7:0]                        x_pos,
  input  logic                              frame_start,
  output logic [8*PIX_PER_WORD-1:0]         pixel_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              sprite0_hit
);

  logic [2:0]                  win_idx_d [PIX_PER_WORD];
  logic [1:0]                  win_val_d [PIX_PER_WORD];
  logic [1:0]                  bg_val_d  [PIX_PER_WORD];
  logic [PIX_PER_WORD-1:0]     hit_vec;
  logic [NUM_SPRITES-1:0]      behind_d;

  logic [2:0]                  win_idx_q [PIX_PER_WORD];
  logic [1:0]                  win_val_q [PIX_PER_WORD];
  logic [1:0]                  bg_val_q  [PIX_PER_WORD];
  logic [NUM_SPRITES-1:0]      behind_q;
  logic [NUM_SPRITES*32-1:0]   spr_colors_q;
  logic [31:0]                 bg_colors_q;
  logic                        s1_valid_q;

  logic                        out_valid_q;
  logic [8*PIX_PER_WORD-1:0]   pixel_out_q, pixel_d;
  logic                        sprite0_hit_q, sprite0_hit_d;
  logic                        load;
  logic                        unused_inputs;

  assign in_ready = !out_valid_q || out_ready;
  assign load     = rst_n && in_valid && in_ready;

  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_attr
    assign behind_d[s] = spr_attr[8*s + ATTR_BEHIND];
  end

  for (genvar p = 0; p < PIX_PER_WORD; p++) begin : g_pix
    logic [8:0]               sx;
    logic                     left, spr_vis, bg_vis;
    logic [2*NUM_SPRITES-1:0] sv;

    // Screen x is kept at 9 bits so pixels past 255 fall out of both clip and hit.
    assign sx      = {1'b0, x_pos} + 9'(p);
    assign left    = sx < 9'd8;
    assign spr_vis = ppu_ctrl2[CTRL2_SPR_EN] && !(left && !ppu_ctrl2[CTRL2_SHOW_SPR_LEFT]);
    assign bg_vis  = ppu_ctrl2[CTRL2_BG_EN] && !(left && !ppu_ctrl2[CTRL2_SHOW_BG_LEFT]);

    for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_sv
      assign sv[2*s +: 2] = {spr_pat_hi[s*PIX_PER_WORD + p], spr_pat_lo[s*PIX_PER_WORD + p]};
    end

    pixel_prio_resolve #(.NUM_SPRITES(NUM_SPRITES)) u_resolve (
      .spr_val_i (sv),
      .bg_val_i  ({bg_pat_hi[p], bg_pat_lo[p]}),
      .spr_vis_i (spr_vis),
      .bg_vis_i  (bg_vis),
      .hit_ok_i  (sx < 9'd255),
      .win_idx_o (win_idx_d[p]),
      .win_val_o (win_val_d[p]),
      .bg_val_o  (bg_val_d[p]),
      .hit_o     (hit_vec[p])
    );
  end

  // A transparent background carries value 0, which selects the backdrop entry.
  always_comb begin
    pixel_d = '0;
    for (int p = 0; p < PIX_PER_WORD; p++) begin
      if (win_val_q[p] != 2'b00 && (!behind_q[win_idx_q[p]] || bg_val_q[p] == 2'b00))
        pixel_d[PAL_W*p +: PAL_W] = spr_colors_q[{win_idx_q[p], win_val_q[p], 3'b000} +: PAL_W];
      else
        pixel_d[PAL_W*p +: PAL_W] = bg_colors_q[{bg_val_q[p], 3'b000} +: PAL_W];
    end
  end

  assign sprite0_hit_d = (sprite0_hit_q && !frame_start) || (load && (|hit_vec));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      pixel_out_q   <= '0;
      sprite0_hit_q <= 1'b0;
    end else begin
      sprite0_hit_q <= sprite0_hit_d;
      if (in_ready) begin
        s1_valid_q  <= in_valid;
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) pixel_out_q <= pixel_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int p = 0; p < PIX_PER_WORD; p++) begin
        win_idx_q[p] <= win_idx_d[p];
        win_val_q[p] <= win_val_d[p];
        bg_val_q[p]  <= bg_val_d[p];
      end
      behind_q     <= behind_d;
      spr_colors_q <= spr_colors;
      bg_colors_q  <= bg_colors;
    end
  end

  assign pixel_out     = pixel_out_q;
  assign out_valid     = out_valid_q;
  assign sprite0_hit   = sprite0_hit_q;
  assign unused_inputs = ^{spr_attr, ppu_ctrl2[7:5], ppu_ctrl2[0]};

endmodule
